dec_lut_req_sequencer: RTL and testbench

- Stage directly upstream of DEC_LUT_Decoder20bits_clk; it also consumes the decoder's result.
- Accepts 34-bit W words over a valid/ready input and drives one word at a time onto the decoder's W port, held stable.
- Waits for found, captures N, and returns {N, W, match, timeout, latency} over a valid/ready output.
- Keeps running pass/error totals against an expected N, replacing the bench-side wait/compare loop in silicon-level test wrappers.

---
 rtl/dec_lut_pkg.sv | 25 ++
 rtl/dec_lut_sat_counter.sv | 26 ++
 rtl/dec_lut_req_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_dec_lut_req_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_lut_pkg.sv
// Shared types and default widths for the DEC_LUT request sequencer and its test wrappers.
package dec_lut_pkg;

    localparam int unsigned DEC_W_BITS   = 34;
    localparam int unsigned DEC_N_BITS   = 21;
    localparam int unsigned DEC_EXP_N    = 1048575;
    localparam int unsigned DEC_LAT_BITS = 21;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WAIT,
        CAPTURE,
        HOLD
    } seq_state_t;

    typedef struct packed {
        logic [DEC_N_BITS-1:0]   n;
        logic [DEC_W_BITS-1:0]   w;
        logic                    match;
        logic                    timeout;
        logic [DEC_LAT_BITS-1:0] latency;
    } dec_result_t;

endpackage

// File: rtl/dec_lut_sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping; synchronous clear wins over increment.
module dec_lut_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/dec_lut_req_sequencer.sv
// Feeds one W word at a time to the LUT decoder, waits for found (or times out) and
// presents the captured result with pass/error totals against an expected N.
module dec_lut_req_sequencer
    import dec_lut_pkg::*;
#(
    parameter int unsigned W_BITS      = DEC_W_BITS,
    parameter int unsigned N_BITS      = DEC_N_BITS,
    parameter int unsigned EXP_N       = DEC_EXP_N,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 1100000,
    parameter int unsigned CNT_BITS    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W_BITS-1:0]   in_w,
    output logic [W_BITS-1:0]   dec_w,
    input  logic                dec_found,
    input  logic [N_BITS-1:0]   dec_n,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_BITS-1:0]   out_n,
    output logic [W_BITS-1:0]   out_w,
    output logic                out_match,
    output logic                out_timeout,
    output logic [20:0]         out_latency,
    output logic                busy,
    output logic [CNT_BITS-1:0] pass_cnt,
    output logic [CNT_BITS-1:0] err_cnt
);

    localparam int unsigned LAT_BITS = DEC_LAT_BITS;
    localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [LAT_BITS-1:0] TIMEOUT_VAL = LAT_BITS'(TIMEOUT_CYC);
    localparam logic [N_BITS-1:0]   EXP_VAL     = N_BITS'(EXP_N);

    seq_state_t            r_state;
    seq_state_t            w_state_next;
    logic                  r_in_ready;
    logic [3:0]            r_settle_cnt;
    logic [W_BITS-1:0]     r_dec_w;
    logic [W_BITS-1:0]     r_w;
    logic [N_BITS-1:0]     r_out_n;
    logic [W_BITS-1:0]     r_out_w;
    logic                  r_out_timeout;
    logic [LAT_BITS-1:0]   r_out_latency;

    logic                  w_accept;
    logic                  w_out_fire;
    logic                  w_timeout_hit;
    logic                  w_lat_clear;
    logic                  w_lat_inc;
    logic [LAT_BITS-1:0]   w_lat_count;
    logic                  w_match;

    assign w_accept      = (r_state == IDLE) && in_valid && r_in_ready;
    assign w_out_fire    = (r_state == HOLD) && out_ready;
    assign w_timeout_hit = (r_state == WAIT) && !dec_found && (w_lat_count == TIMEOUT_VAL);

    always_comb begin
        w_state_next = r_state;
        w_lat_clear  = 1'b0;
        w_lat_inc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_next = WAIT;
                    w_lat_clear  = 1'b1;
                end
            end
            WAIT: begin
                // found takes priority over a timeout landing on the same cycle
                if (dec_found) begin
                    w_state_next = CAPTURE;
                end else if (w_lat_count == TIMEOUT_VAL) begin
                    w_state_next = HOLD;
                end else begin
                    w_lat_inc = 1'b1;
                end
            end
            CAPTURE: begin
                w_state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt  <= '0;
            r_dec_w       <= '0;
            r_w           <= '0;
            r_out_n       <= '0;
            r_out_w       <= '0;
            r_out_timeout <= 1'b0;
            r_out_latency <= '0;
        end else begin
            if (w_accept) begin
                r_dec_w      <= in_w;
                r_w          <= in_w;
                r_settle_cnt <= '0;
            end
            if (r_state == SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end
            // dec_n is sampled one cycle after found so the LUT output has settled
            if (r_state == CAPTURE) begin
                r_out_n       <= dec_n;
                r_out_w       <= r_w;
                r_out_latency <= w_lat_count;
                r_out_timeout <= 1'b0;
            end
            if (w_timeout_hit) begin
                r_out_n       <= '0;
                r_out_w       <= r_w;
                r_out_latency <= w_lat_count;
                r_out_timeout <= 1'b1;
            end
        end
    end

    dec_lut_sat_counter #(
        .WIDTH (LAT_BITS)
    ) u_lat_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_lat_clear),
        .i_inc   (w_lat_inc),
        .o_count (w_lat_count)
    );

    assign w_match = (r_out_n == EXP_VAL) && !r_out_timeout;

    dec_lut_sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_pass_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (1'b0),
        .i_inc   (w_out_fire && w_match),
        .o_count (pass_cnt)
    );

    dec_lut_sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (1'b0),
        .i_inc   (w_out_fire && !w_match),
        .o_count (err_cnt)
    );

    assign in_ready    = r_in_ready;
    assign dec_w       = r_dec_w;
    assign out_valid   = (r_state == HOLD);
    assign out_n       = r_out_n;
    assign out_w       = r_out_w;
    assign out_match   = w_match;
    assign out_timeout = r_out_timeout;
    assign out_latency = r_out_latency;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_dec_lut_req_sequencer.sv
// Directed bench for the request sequencer: a cycle-count model predicts every output each
// cycle, and literal expectations pin the key results of each scenario.
module tb_dec_lut_req_sequencer;
    import dec_lut_pkg::*;

    localparam int S        = 2;
    localparam int T        = 20;
    localparam int CB       = 2;
    localparam logic [20:0] EXP = 21'd1048575;
    localparam int CNT_MAX  = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [33:0]   in_w = '0;
    logic [33:0]   dec_w;
    logic          dec_found = 1'b0;
    logic [20:0]   dec_n = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [20:0]   out_n;
    logic [33:0]   out_w;
    logic          out_match;
    logic          out_timeout;
    logic [20:0]   out_latency;
    logic          busy;
    logic [CB-1:0] pass_cnt;
    logic [CB-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    dec_lut_req_sequencer #(
        .SETTLE_CYC  (S),
        .TIMEOUT_CYC (T),
        .CNT_BITS    (CB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_w        (in_w),
        .dec_w       (dec_w),
        .dec_found   (dec_found),
        .dec_n       (dec_n),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_n       (out_n),
        .out_w       (out_w),
        .out_match   (out_match),
        .out_timeout (out_timeout),
        .out_latency (out_latency),
        .busy        (busy),
        .pass_cnt    (pass_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: tracks edges since accept; SETTLE edges ignore found, edge S+1+k is wait sample k.
    bit          m_req = 0, m_cap = 0, m_hold = 0, m_in_ready = 0;
    int          m_age = 0, m_k = 0;
    logic [33:0] m_dec_w = '0;
    int          m_pass = 0, m_err = 0;
    dec_result_t m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req = 0; m_cap = 0; m_hold = 0; m_in_ready = 0;
            m_dec_w = '0; m_pass = 0; m_err = 0; m_res = '0;
        end else begin
            if (m_hold) begin
                if (out_ready) begin
                    if (m_res.match) m_pass = (m_pass < CNT_MAX) ? m_pass + 1 : m_pass;
                    else             m_err  = (m_err  < CNT_MAX) ? m_err + 1  : m_err;
                    m_hold = 0;
                end
            end else if (m_cap) begin
                m_res.n       = dec_n;
                m_res.match   = (dec_n == EXP);
                m_res.timeout = 1'b0;
                m_res.latency = 21'(m_k);
                m_cap  = 0;
                m_hold = 1;
            end else if (m_req) begin
                m_age++;
                if (m_age > S) begin
                    if (dec_found) begin
                        m_k   = m_age - 1 - S;
                        m_cap = 1;
                        m_req = 0;
                    end else if (m_age - 1 - S == T) begin
                        m_res.n       = '0;
                        m_res.match   = 1'b0;
                        m_res.timeout = 1'b1;
                        m_res.latency = 21'(T);
                        m_req  = 0;
                        m_hold = 1;
                    end
                end
            end else if (m_in_ready && in_valid) begin
                m_req   = 1;
                m_age   = 0;
                m_dec_w = in_w;
                m_res.w = in_w;
            end
            m_in_ready = !(m_req || m_cap || m_hold);
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, m_in_ready);
        check("out_valid", out_valid, m_hold);
        check("busy", busy, !m_in_ready && rst_n && (m_req || m_cap || m_hold));
        check("dec_w", dec_w, m_dec_w);
        check("pass_cnt", pass_cnt, m_pass);
        check("err_cnt", err_cnt, m_err);
        if (m_hold) begin
            check("out_n", out_n, m_res.n);
            check("out_w", out_w, m_res.w);
            check("out_match", out_match, m_res.match);
            check("out_timeout", out_timeout, m_res.timeout);
            check("out_latency", out_latency, m_res.latency);
        end
    end

    // found_j: -1 never, -2 high before accept, else raised at negedge j after the accept edge
    task automatic run_req(input logic [33:0] w, input int found_j, input logic [20:0] nval,
                           input int ready_delay, output int valid_cyc, output dec_result_t r);
        out_ready = (ready_delay == 0);
        if (found_j == -2) begin
            dec_found = 1'b1;
            dec_n     = nval;
        end
        in_valid = 1'b1;
        in_w     = w;
        @(negedge clk);
        in_valid  = 1'b0;
        valid_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                valid_cyc = i;
                break;
            end
            if (found_j == i) begin
                dec_found = 1'b1;
                dec_n     = nval;
            end
            @(negedge clk);
        end
        if (valid_cyc < 0) check("out_valid_wait", out_valid, 1'b1);
        r.n = out_n; r.w = out_w; r.match = out_match;
        r.timeout = out_timeout; r.latency = out_latency;
        for (int i = 0; i < ready_delay; i++) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        dec_found = 1'b0;
    endtask

    initial begin
        int          vc;
        dec_result_t r;

        #1 rst_n = 1'b0;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_pass", pass_cnt, 0);
        check("rst_err", err_cnt, 0);
        in_valid = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);

        // reset abandons a request sitting in WAIT
        in_valid = 1'b1; in_w = 34'd4242;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midwait_busy", busy, 1'b1);
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midwait_out_valid", out_valid, 1'b0);
        check("midwait_busy_rst", busy, 1'b0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midwait_pass", pass_cnt, 0);
        check("midwait_err", err_cnt, 0);
        check("midwait_in_ready", in_ready, 1'b1);

        run_req(34'd12345, S + 7, EXP, 0, vc, r);
        $display("req nominal: n=%0d w=%0d match=%0b lat=%0d", r.n, r.w, r.match, r.latency);
        check("nom_n", r.n, 21'd1048575);
        check("nom_w", r.w, 34'd12345);
        check("nom_match", r.match, 1'b1);
        check("nom_latency", r.latency, 21'd7);
        check("nom_pass", pass_cnt, 1);

        run_req(34'd777, S + 3, 21'd1048574, 10, vc, r);
        $display("req mismatch: n=%0d w=%0d match=%0b lat=%0d", r.n, r.w, r.match, r.latency);
        check("mis_match", r.match, 1'b0);
        check("mis_n", r.n, 21'd1048574);
        check("mis_latency", r.latency, 21'd3);
        check("mis_err", err_cnt, 1);

        run_req(34'd5, -2, EXP, 0, vc, r);
        $display("req early-found: valid after %0d cycles lat=%0d", vc, r.latency);
        check("early_valid_cyc", vc, 4);
        check("early_latency", r.latency, 21'd0);
        check("early_pass", pass_cnt, 2);

        run_req(34'd99, -1, 21'd0, 0, vc, r);
        $display("req timeout: valid after %0d cycles to=%0b lat=%0d", vc, r.timeout, r.latency);
        check("to_timeout", r.timeout, 1'b1);
        check("to_n", r.n, 21'd0);
        check("to_latency", r.latency, 21'd20);
        check("to_valid_cyc", vc, 23);
        check("to_err", err_cnt, 2);

        for (int i = 0; i < 3; i++) begin
            run_req(34'(100 + i), S + i, EXP, 0, vc, r);
            $display("req sat %0d: pass_cnt=%0d lat=%0d", i, pass_cnt, r.latency);
        end
        check("sat_pass", pass_cnt, 3);
        check("sat_err", err_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
